// File: rtl/sc_environment_timer.sv
// Event source for the environment state machine: paces transition screens,
// issues acknowledged road-scroll requests, and tracks level progress and the win.
module sc_environment_timer #(
  parameter int PRESCALE         = 500000,
  parameter int TRANS_TICKS      = 200,
  parameter int DOWN_TICKS_L1    = 8,
  parameter int DOWN_TICKS_L2    = 5,
  parameter int DOWN_TICKS_L3    = 3,
  parameter int SHIFTS_PER_LEVEL = 64
) (
  input  logic       SC_ENVIRONMENT_TIMER_CLOCK_50,
  input  logic       SC_ENVIRONMENT_TIMER_RESET_InHigh,
  input  logic       SC_ENVIRONMENT_TIMER_CLEAR_InLow,
  input  logic       SC_ENVIRONMENT_TIMER_ENABLECOUNT_InLow,
  input  logic       SC_ENVIRONMENT_TIMER_SCREENSELECTOR_In,
  input  logic       SC_ENVIRONMENT_TIMER_LOAD_InLow,
  output logic       SC_ENVIRONMENT_TIMER_TRANSITION_OutLow,
  output logic       SC_ENVIRONMENT_TIMER_DOWN_OutLow,
  output logic       SC_ENVIRONMENT_TIMER_WIN_OutLow,
  output logic [2:0] SC_ENVIRONMENT_TIMER_LEVEL_OutBus
);

  localparam int DN_MAX = (DOWN_TICKS_L1 > DOWN_TICKS_L2) ?
                          ((DOWN_TICKS_L1 > DOWN_TICKS_L3) ? DOWN_TICKS_L1 : DOWN_TICKS_L3) :
                          ((DOWN_TICKS_L2 > DOWN_TICKS_L3) ? DOWN_TICKS_L2 : DOWN_TICKS_L3);
  localparam int PRE_W = (PRESCALE > 1)         ? $clog2(PRESCALE)         : 1;
  localparam int TR_W  = (TRANS_TICKS > 1)      ? $clog2(TRANS_TICKS)      : 1;
  localparam int DN_W  = (DN_MAX > 1)           ? $clog2(DN_MAX)           : 1;
  localparam int SH_W  = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [TR_W-1:0]  TR_LAST  = TR_W'(TRANS_TICKS - 1);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SHIFTS_PER_LEVEL - 1);

  typedef enum logic [1:0] {D_IDLE, D_REQ, D_DONE} dn_state_t;

  logic             clk;
  logic             kill;
  logic [PRE_W-1:0] tr_pre;
  logic [TR_W-1:0]  tr_cnt;
  logic             trans_n_q;
  dn_state_t        dn_state;
  logic [PRE_W-1:0] dn_pre;
  logic [DN_W-1:0]  dn_cnt;
  logic [SH_W-1:0]  scroll_cnt;
  logic             down_n_q;
  logic             win_n_q;
  logic [2:0]       level_q;

  assign clk  = SC_ENVIRONMENT_TIMER_CLOCK_50;
  assign kill = SC_ENVIRONMENT_TIMER_RESET_InHigh | ~SC_ENVIRONMENT_TIMER_CLEAR_InLow;

  // Terminal tick count for the current level's scroll period.
  function automatic logic [DN_W-1:0] down_last(input logic [2:0] lv);
    case (lv)
      3'd1:    down_last = DN_W'(DOWN_TICKS_L1 - 1);
      3'd2:    down_last = DN_W'(DOWN_TICKS_L2 - 1);
      default: down_last = DN_W'(DOWN_TICKS_L3 - 1);
    endcase
  endfunction

  // Transition timer: any cycle with enable high discards partial progress.
  always_ff @(posedge clk) begin
    if (kill || SC_ENVIRONMENT_TIMER_ENABLECOUNT_InLow) begin
      tr_pre    <= '0;
      tr_cnt    <= '0;
      trans_n_q <= 1'b1;
    end else begin
      trans_n_q <= 1'b1;
      if (tr_pre == PRE_LAST) begin
        tr_pre <= '0;
        if (tr_cnt == TR_LAST) begin
          tr_cnt    <= '0;
          trans_n_q <= 1'b0;
        end else begin
          tr_cnt <= tr_cnt + 1'b1;
        end
      end else begin
        tr_pre <= tr_pre + 1'b1;
      end
    end
  end

  // Scroll request FSM with level/win bookkeeping on each acknowledge.
  always_ff @(posedge clk) begin
    if (kill) begin
      dn_state   <= D_IDLE;
      dn_pre     <= '0;
      dn_cnt     <= '0;
      scroll_cnt <= '0;
      down_n_q   <= 1'b1;
      win_n_q    <= 1'b1;
      level_q    <= 3'd1;
    end else begin
      case (dn_state)
        D_IDLE: begin
          down_n_q <= 1'b1;
          if (SC_ENVIRONMENT_TIMER_SCREENSELECTOR_In || !win_n_q) begin
            dn_pre <= '0;
            dn_cnt <= '0;
          end else if (dn_pre == PRE_LAST) begin
            dn_pre <= '0;
            if (dn_cnt == down_last(level_q)) begin
              dn_cnt   <= '0;
              dn_state <= D_REQ;
              down_n_q <= 1'b0;
            end else begin
              dn_cnt <= dn_cnt + 1'b1;
            end
          end else begin
            dn_pre <= dn_pre + 1'b1;
          end
        end
        D_REQ: begin
          // Acknowledge takes precedence over a screen change in the same cycle.
          if (!SC_ENVIRONMENT_TIMER_LOAD_InLow) begin
            dn_state <= D_DONE;
            down_n_q <= 1'b1;
            if (scroll_cnt == SH_LAST) begin
              scroll_cnt <= '0;
              if (level_q < 3'd3) level_q <= level_q + 3'd1;
              else                win_n_q <= 1'b0;
            end else begin
              scroll_cnt <= scroll_cnt + 1'b1;
            end
          end else if (SC_ENVIRONMENT_TIMER_SCREENSELECTOR_In) begin
            dn_state <= D_IDLE;
            down_n_q <= 1'b1;
          end
        end
        D_DONE: begin
          dn_state <= D_IDLE;
          down_n_q <= 1'b1;
        end
        default: begin
          dn_state <= D_IDLE;
          down_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign SC_ENVIRONMENT_TIMER_TRANSITION_OutLow = trans_n_q;
  assign SC_ENVIRONMENT_TIMER_DOWN_OutLow       = down_n_q;
  assign SC_ENVIRONMENT_TIMER_WIN_OutLow        = win_n_q;
  assign SC_ENVIRONMENT_TIMER_LEVEL_OutBus      = level_q;

endmodule
